// File: rtl/cic_interpolator_if.sv
// Sample-stream bundle for the CIC interpolator: low-rate input handshake
// plus the fast-rate output strobe.
interface cic_interpolator_if #(
   parameter int unsigned X_WIDTH = 12,
   parameter int unsigned Y_WIDTH = X_WIDTH
);
   logic signed [X_WIDTH-1:0] x;
   logic                      x_valid;
   logic                      x_ready;
   logic signed [Y_WIDTH-1:0] y;
   logic                      y_valid;

   modport master (
      output x, x_valid,
      input  x_ready, y, y_valid
   );

   modport slave (
      input  x, x_valid,
      output x_ready, y, y_valid
   );
endinterface

// File: rtl/cic_interpolator.sv
// M-stage CIC interpolator by R: combs at the input rate, zero-stuffing,
// and a pipelined integrator cascade at the clock rate, all clock-enabled.
module cic_interpolator #(
   parameter int unsigned R       = 4,
   parameter int unsigned M       = 2,
   parameter int unsigned X_WIDTH = 12,
   parameter int unsigned Y_WIDTH = X_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enabled,
   cic_interpolator_if.slave  bus
);
   localparam int unsigned K     = $clog2(R);
   localparam int unsigned W     = X_WIDTH + M * K;
   localparam int unsigned Y_MSB = X_WIDTH + (M - 1) * K - 1;

   logic [K-1:0]          p_q, p_d;
   logic signed [W-1:0]   dly_q [M];
   logic signed [W-1:0]   dly_d [M];
   logic signed [W-1:0]   integ_q [M];
   logic signed [W-1:0]   integ_d [M];
   logic                  y_valid_q, y_valid_d;

   logic                  ready;
   logic                  accept;
   logic                  step;
   logic signed [W-1:0]   comb_v;
   logic signed [W-1:0]   stuff;
   logic                  unused_ok;

   always_comb begin
      ready  = enabled && (p_q == '0);
      accept = bus.x_valid && ready;
      step   = accept || (enabled && (p_q != '0));

      p_d       = p_q;
      dly_d     = dly_q;
      integ_d   = integ_q;
      y_valid_d = step;

      // Comb chain walked through one running value so each delay captures its stage input.
      comb_v = {{(W - X_WIDTH){bus.x[X_WIDTH-1]}}, bus.x};
      for (int unsigned i = 0; i < M; i++) begin
         if (accept) dly_d[i] = comb_v;
         comb_v = comb_v - dly_q[i];
      end
      stuff = accept ? comb_v : '0;

      // R is a power of two, so the phase wraps to 0 naturally after R-1.
      if (accept) begin
         p_d = K'(1);
      end else if (enabled && (p_q != '0)) begin
         p_d = p_q + K'(1);
      end

      if (step) begin
         integ_d[0] = integ_q[0] + stuff;
         for (int unsigned i = 1; i < M; i++) begin
            integ_d[i] = integ_q[i] + integ_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q       <= '0;
         y_valid_q <= 1'b0;
         for (int unsigned i = 0; i < M; i++) begin
            dly_q[i]   <= '0;
            integ_q[i] <= '0;
         end
      end else begin
         p_q       <= p_d;
         y_valid_q <= y_valid_d;
         dly_q     <= dly_d;
         integ_q   <= integ_d;
      end
   end

   // Truncating slice divides out the R^(M-1) DC gain of the cascade.
   assign bus.x_ready = ready;
   assign bus.y       = integ_q[M-1][Y_MSB -: Y_WIDTH];
   assign bus.y_valid = y_valid_q;

   assign unused_ok = ^integ_q[M-1];
endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Multistage cascaded integrator-comb (CIC) interpolator for the MSO signal path. It is the inverse-direction partner of the sample decimator: it accepts low-rate signed samples through a valid/ready handshake and emits R output samples per input at the fast clock rate. Its main use is reconstruction and upsampling of decimated captures toward display or DAC paths. The combs run at the input rate, zero-stuffing performs the upsampling, and the integrators run at the output rate. All stages are clocked from `clk` using clock enables; no derived clocks are used.

## Interface
- R, 4: interpolation factor; power of two, 2..256; K = log2(R)
- M, 2: number of comb stages and number of integrator stages; 1..6
- X_WIDTH, 12: input sample width, signed
- Y_WIDTH, X_WIDTH: output width; must satisfy Y_WIDTH <= X_WIDTH
- W (localparam) = X_WIDTH + M*K: internal datapath width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enabled  in  1  global clock enable; low freezes all state
- x  in  X_WIDTH  signed input sample
- x_valid  in  1  input sample present
- x_ready  out  1  block accepts x this cycle
- y  out  Y_WIDTH  signed output sample
- y_valid  out  1  y carries a new output sample this cycle

## Operation
- Phase counter p runs 0..R-1 and resets to 0.
- x_ready = enabled & (p == 0). This output is combinational.
- accept = x_valid & x_ready.
- Comb chain:
  - c_0 = sign-extend(x) to W.
  - Stage i output is c_(i+1) = c_i - dly_i.
  - This is a combinational subtract chain with differential delay fixed at 1.
  - On accept, each dly_i <= c_i.
- Zero-stuff:
  - s = c_M on the accept cycle.
  - s = 0 on the cycles with p = 1..R-1.
- Step:
  - step = accept | (enabled & p != 0).
  - On step: I_0 <= I_0 + s, and I_i <= I_i + I_(i-1) using the registered value of I_(i-1).
  - This forms a pipelined integrator cascade.
- Phase advance:
  - On accept, p <= 1.
  - On enabled & p != 0, p <= (p == R-1) ? 0 : p+1.
  - With p == 0 and no x_valid, the block stalls: p holds, no step occurs, and integrators hold.
- Arithmetic:
  - All adds and subtracts are W-bit two's complement with wrap. Wrap is intentional and correct for CIC.
  - No saturation is applied internally.
- Output scaling:
  - y = I_(M-1)[X_WIDTH+(M-1)K-1 -: Y_WIDTH]. This is a truncating slice with no rounding.
  - DC gain is R^(M-1); the slice divides by it, giving unity DC gain when Y_WIDTH == X_WIDTH.
- enabled low:
  - p, dly_i and I_i all hold.
  - x_ready is 0.
  - Operation resumes at the same phase when enabled returns high.

## Timing
- Reset (rst_n low at a clk edge):
  - p = 0, all dly_i = 0, all I_i = 0.
  - y = 0, y_valid = 0.
  - x_ready = enabled after reset.
- y_valid is registered and equals step delayed by 1 cycle. Exactly one y_valid pulse follows each step.
- y is stable between y_valid pulses.
- Latency: a sample accepted in cycle t first affects y in cycle t+M.
- Sustained throughput:
  - With x_valid held high: one accept per R cycles and y_valid high every cycle.
  - x_ready pattern is 1 followed by R-1 zeros.
- Simultaneous events: rst_n low overrides enabled and x_valid. Reset mid-burst discards the partial phase.
- x_valid asserted while x_ready is low is ignored. x must be held by the source until accepted.

## Test plan
All scenarios use defaults: R=4, M=2, X=Y=12, W=16.
- Reset:
  - Stimulus: assert rst_n low for 2 cycles with enabled=1.
  - Required response: y=0, y_valid=0, p=0; x_ready=1 on the first cycle after release.
- DC:
  - Stimulus: x=100 with x_valid held high.
  - Required response: x_ready pattern 1,0,0,0 repeating; y_valid continuously high after the first step; y reaches 100 within 10 valid outputs and stays at 100.
- Impulse:
  - Stimulus: one accepted sample x=4, then x=0 on all later accepts.
  - Required response: after M cycles of latency, y over consecutive valid outputs is 1,2,3,4,3,2,1, then 0 forever.
- Stall:
  - Stimulus: with continuous x=100 in progress, drop x_valid for 5 cycles at p=0.
  - Required response: y_valid is low for 5 cycles (offset by 1), y holds, p stays 0; the stream resumes with no lost or duplicated phase.
- Enable freeze:
  - Stimulus: drive enabled low for 3 cycles while p=2.
  - Required response: x_ready=0 and y_valid=0 during the freeze; p, y and state unchanged; the next steps are p=2 then p=3.
- Full scale with reset mid-operation:
  - Stimulus: assert reset mid-burst, then feed x=-2048 constant.
  - Required response: y settles to -2048 and stays there with no wrap artefacts; a later x=2047 constant settles to 2047.
